// File: rtl/oak8m14.sv
// Wishbone-programmable 8-bit sample playback engine.
// Samples in a small RAM are played to an external DAC at a programmable period.
module oak8m14 #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          RAM_DEPTH = 256,
    parameter int          DIV_WIDTH = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);
    localparam int AW = $clog2(RAM_DEPTH);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    logic [7:0]           r_ram [RAM_DEPTH];
    state_t               r_state, w_state_nxt;
    logic [AW-1:0]        r_addr, w_addr_nxt;
    logic [DIV_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [8:0]           r_len;
    logic [8:0]           w_len_eff;
    logic [7:0]           r_dac;
    logic                 r_dac_start, r_addr_zero;
    logic                 r_run, r_loop;
    logic                 r_ack;
    logic [31:0]          r_dat;
    logic                 w_load, w_run_clr, w_last;

    logic                 w_stb, w_req, w_wr, w_rd;
    logic                 w_in_range, w_ram_sel, w_reg_sel, w_ram_stb;
    logic [AW-1:0]        w_ram_idx;
    logic [7:0]           w_reg_off;
    logic [31:0]          w_rdata;
    logic                 w_state_run, w_active;
    logic                 w_unused;

    // The block owns a 2 KB window: registers below 0x400, RAM above.
    assign w_stb      = wbs_stb_i & wbs_cyc_i;
    assign w_req      = w_stb & ~r_ack;
    assign w_wr       = w_req & wbs_we_i;
    assign w_rd       = w_req & ~wbs_we_i;
    assign w_in_range = (wbs_adr_i & ~32'h0000_07FF) == BASE_ADDR;
    assign w_ram_sel  = w_in_range & wbs_adr_i[10];
    assign w_reg_sel  = w_in_range & ~wbs_adr_i[10];
    assign w_ram_idx  = wbs_adr_i[2 +: AW];
    assign w_reg_off  = wbs_adr_i[9:2];
    assign w_ram_stb  = w_stb & w_ram_sel;
    assign w_unused   = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

    assign w_state_run = (r_state == S_RUN);
    assign w_active    = w_state_run | wbs_cyc_i;

    // Zero and oversize lengths both mean "the whole RAM".
    assign w_len_eff = (r_len == 9'd0 || r_len > 9'(RAM_DEPTH)) ? 9'(RAM_DEPTH) : r_len;
    assign w_last    = (9'(r_addr) == w_len_eff - 9'd1);

    always_comb begin
        w_rdata = '0;
        if (w_ram_sel) begin
            w_rdata[7:0] = r_ram[w_ram_idx];
        end else if (w_reg_sel) begin
            case (w_reg_off)
                8'd0: w_rdata[1:0] = {r_loop, r_run};
                8'd1: w_rdata[DIV_WIDTH-1:0] = r_div;
                8'd2: w_rdata[8:0] = r_len;
                8'd3: begin
                    w_rdata[0]       = w_state_run;
                    w_rdata[8 +: AW] = r_addr;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_run_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_run) begin
                    w_state_nxt = S_RUN;
                    w_addr_nxt  = '0;
                    w_cnt_nxt   = r_div;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                if (!r_run) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
                end else begin
                    w_cnt_nxt = r_div;
                    if (w_last && !r_loop) begin
                        w_state_nxt = S_IDLE;
                        w_run_clr   = 1'b1;
                    end else begin
                        w_addr_nxt = w_last ? '0 : r_addr + AW'(1);
                        w_load     = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_dac       <= '0;
            r_dac_start <= 1'b0;
            r_addr_zero <= 1'b0;
            r_run       <= 1'b0;
            r_loop      <= 1'b0;
            r_div       <= '0;
            r_len       <= '0;
            r_ack       <= 1'b0;
            r_dat       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dac_start <= w_load;
            r_addr_zero <= (w_addr_nxt == '0);
            if (w_load) begin
                r_dac <= r_ram[w_addr_nxt];
            end
            r_ack <= w_stb & ~r_ack;
            r_dat <= w_rd ? w_rdata : '0;
            if (w_run_clr) begin
                r_run <= 1'b0;
            end
            // A bus write to CTRL in the same cycle overrides the end-of-play clear.
            if (w_wr && w_reg_sel) begin
                case (w_reg_off)
                    8'd0: if (wbs_sel_i[0]) {r_loop, r_run} <= wbs_dat_i[1:0];
                    8'd1: for (int i = 0; i < DIV_WIDTH; i++) begin
                        if (wbs_sel_i[i/8]) r_div[i] <= wbs_dat_i[i];
                    end
                    8'd2: for (int i = 0; i < 9; i++) begin
                        if (wbs_sel_i[i/8]) r_len[i] <= wbs_dat_i[i];
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the sample RAM has no reset so it maps onto plain storage; contents survive wb_rst_i.
    always_ff @(posedge wb_clk_i) begin
        if (w_wr && w_ram_sel && wbs_sel_i[0]) begin
            r_ram[w_ram_idx] <= wbs_dat_i[7:0];
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign io_out = {16'b0, w_active, w_stb, w_ram_stb, r_dac_start,
                     w_state_run, r_addr_zero, r_dac, 8'b0};
    assign io_oeb = {16'hFFFF, 14'b0, 8'hFF};

endmodule

// File: tb/tb_oak8m14.sv
// Scoreboard bench for oak8m14: bus reads and DAC updates are predicted from a
// sample-list model of playback and checked by independent monitors.
module tb_oak8m14;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h000;
    localparam logic [31:0] A_DIV  = BASE + 32'h004;
    localparam logic [31:0] A_LEN  = BASE + 32'h008;
    localparam logic [31:0] A_STAT = BASE + 32'h00C;
    localparam logic [31:0] A_RAM  = BASE + 32'h400;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic [37:0] io_out, io_oeb;

    oak8m14 dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_w),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_r),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Behavioural model: sample memory plus programmed registers.
    logic [7:0]  ram_m [256];
    logic [15:0] div_m;
    logic [8:0]  len_m;

    typedef struct {
        logic [31:0] val;
        logic [31:0] mask;
        string       name;
    } rd_exp_t;

    typedef struct {
        logic [7:0] val;
        int         at;
        logic       first;
    } dac_exp_t;

    rd_exp_t  rd_q[$];
    dac_exp_t dac_q[$];

    // Read monitor: every acked read is matched against the oldest prediction.
    always @(negedge clk) begin
        rd_exp_t e;
        if (!rst && ack && !we) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 64'(rd_q.size()), 64'd1);
            end else begin
                e = rd_q.pop_front();
                check(e.name, 64'(dat_r & e.mask), 64'(e.val & e.mask));
            end
        end
    end

    // DAC monitor: every dac_start pulse must match the predicted sample, cycle and addr==0 flag.
    always @(negedge clk) begin
        dac_exp_t e;
        if (!rst && io_out[18]) begin
            if (dac_q.size() == 0) begin
                check("dac_unexpected_start", 64'(dac_q.size()), 64'd1);
            end else begin
                e = dac_q.pop_front();
                check("dac_value", 64'(io_out[15:8]), 64'(e.val));
                check("dac_cycle", 64'(cyc_cnt), 64'(e.at));
                check("ram_addr_zero", 64'(io_out[16]), 64'(e.first));
            end
        end
    end

    task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                           input logic [3:0] s, output int t_ack, output logic [1:0] dbg);
        int lat;
        @(negedge clk);
        adr = a; dat_w = d; we = w; sel = s; stb = 1'b1; cyc = 1'b1;
        #1 dbg = io_out[20:19];
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ack) begin
                lat = i;
                break;
            end
        end
        t_ack = cyc_cnt;
        stb = 1'b0; cyc = 1'b0;
        check("ack_latency", 64'(lat), 64'd1);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int t; logic [1:0] g;
        wb_xfer(a, d, 1'b1, s, t, g);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] exp_v,
                           input logic [31:0] mask, input string name);
        int t; logic [1:0] g;
        rd_exp_t e;
        e.val = exp_v; e.mask = mask; e.name = name;
        rd_q.push_back(e);
        wb_xfer(a, 32'h0, 1'b0, 4'hF, t, g);
    endtask

    task automatic set_div(input logic [15:0] v);
        wb_write(A_DIV, {16'hA5A5, v}, 4'hF);
        div_m = v;
    endtask

    task automatic set_len(input logic [8:0] v);
        wb_write(A_LEN, {23'h0, v}, 4'hF);
        len_m = v;
    endtask

    task automatic ram_write(input int idx, input logic [7:0] v);
        wb_write(A_RAM + 32'(idx * 4), {24'hC3C3C3, v}, 4'hF);
        ram_m[idx] = v;
    endtask

    // Start playback and predict it: sample i of the list appears at t0 + i*(DIV+1).
    task automatic play(input logic loop, input logic do_stop, input int stop_after);
        int n, p, t0, t_ack, cs, horizon, idx;
        logic [1:0] g;
        dac_exp_t e;
        n = (len_m == 9'd0 || len_m > 9'd256) ? 256 : int'(len_m);
        p = int'(div_m) + 1;
        wb_xfer(A_CTRL, {30'h0, loop, 1'b1}, 1'b1, 4'hF, t_ack, g);
        t0 = t_ack + 1;
        horizon = t0 + stop_after + 20;
        for (int i = 0; ; i++) begin
            if (!loop && i >= n) break;
            if (do_stop && t0 + i * p > horizon) break;
            e.val = ram_m[i % n]; e.at = t0 + i * p; e.first = ((i % n) == 0);
            dac_q.push_back(e);
        end
        if (!do_stop) begin
            while (cyc_cnt < t0 + n * p - 1) @(negedge clk);
            check("run_during_last_period", 64'(io_out[17]), 64'd1);
            @(negedge clk);
            check("run_after_last_period", 64'(io_out[17]), 64'd0);
            check("dac_hold_last", 64'(io_out[15:8]), 64'(ram_m[n-1]));
            check("dac_q_drained", 64'(dac_q.size()), 64'd0);
            wb_read(A_CTRL, 32'h0, 32'hFFFF_FFFF, "ctrl_run_cleared");
        end else begin
            while (cyc_cnt < t0 + stop_after) @(negedge clk);
            if (loop) wb_read(A_STAT, 32'h1, 32'hFFFF_00FF, "status_running");
            wb_xfer(A_CTRL, {30'h0, loop, 1'b0}, 1'b1, 4'hF, cs, g);
            while (dac_q.size() > 0 && dac_q[$].at > cs) void'(dac_q.pop_back());
            idx = (cs - t0) / p;
            repeat (3 * p + 5) @(negedge clk);
            check("run_after_stop", 64'(io_out[17]), 64'd0);
            check("dac_hold_after_stop", 64'(io_out[15:8]), 64'(ram_m[idx % n]));
            check("dac_q_drained_stop", 64'(dac_q.size()), 64'd0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        logic [1:0] g;
        dac_exp_t e;
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; dat_w = 32'h0;
        div_m = '0; len_m = '0;

        repeat (3) @(negedge clk);
        check("reset_io_out", 64'(io_out), 64'd0);
        check("reset_ack", 64'(ack), 64'd0);
        check("reset_dat", 64'(dat_r), 64'd0);
        check("reset_io_oeb", 64'(io_oeb), 64'h3F_FFC0_00FF);
        @(negedge clk) rst = 1'b0;

        // Register access and decode.
        wb_xfer(A_DIV, 32'h0000_1234, 1'b1, 4'hF, t, g);
        div_m = 16'h1234;
        check("dbg_div_write_strobes", 64'(g), 64'b10);
        wb_read(A_DIV, 32'h1234, 32'hFFFF_FFFF, "div_readback");
        wb_read(BASE + 32'h010, 32'h0, 32'hFFFF_FFFF, "unmapped_reg_read");
        wb_read(32'h4000_0000, 32'h0, 32'hFFFF_FFFF, "out_of_range_read");
        wb_read(A_CTRL, 32'h0, 32'hFFFF_FFFF, "ctrl_reset_value");

        // RAM load, byte select and readback.
        wb_xfer(A_RAM, 32'hFFFF_FF11, 1'b1, 4'hF, t, g);
        ram_m[0] = 8'h11;
        check("dbg_ram_write_strobes", 64'(g), 64'b11);
        ram_write(1, 8'h22);
        ram_write(2, 8'h33);
        ram_write(3, 8'h44);
        wb_write(A_RAM + 32'd4, 32'h0000_00FF, 4'b1110);
        wb_read(A_RAM + 32'd4, 32'h22, 32'hFFFF_FFFF, "ram_sel0_ignored");
        wb_read(A_RAM + 32'd8, 32'h33, 32'hFFFF_FFFF, "ram_readback");

        // One-shot, loop, and stop while sample 0x22 is on the DAC.
        set_div(16'd3);
        set_len(9'd4);
        wb_read(A_LEN, 32'h4, 32'hFFFF_FFFF, "len_readback");
        play(1'b0, 1'b0, 0);
        play(1'b1, 1'b1, 20);
        play(1'b0, 1'b1, 4);

        // Asynchronous reset in the middle of looping playback.
        wb_xfer(A_CTRL, 32'h3, 1'b1, 4'hF, t, g);
        for (int i = 0; i < 10; i++) begin
            e.val = ram_m[i % 4]; e.at = t + 1 + i * 4; e.first = ((i % 4) == 0);
            dac_q.push_back(e);
        end
        while (cyc_cnt < t + 10) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        dac_q.delete();
        #1;
        check("midrun_reset_io_out", 64'(io_out), 64'd0);
        check("midrun_reset_ack", 64'(ack), 64'd0);
        @(negedge clk) rst = 1'b0;
        div_m = '0; len_m = '0;
        wb_read(A_CTRL, 32'h0, 32'hFFFF_FFFF, "ctrl_after_reset");
        wb_read(A_DIV, 32'h0, 32'hFFFF_FFFF, "div_after_reset");
        wb_read(A_LEN, 32'h0, 32'hFFFF_FFFF, "len_after_reset");
        wb_read(A_STAT, 32'h0, 32'hFFFF_FFFF, "status_after_reset");
        wb_read(A_RAM + 32'd12, 32'h44, 32'hFFFF_FFFF, "ram_kept_over_reset");

        // Randomised playbacks, including LEN = 0 and LEN above the RAM depth.
        for (int r = 0; r < 5; r++) begin
            int n, p, sel_len;
            logic lp;
            sel_len = int'($urandom_range(0, 3));
            if (r == 0) sel_len = 0;
            if (r == 1) sel_len = 1;
            case (sel_len)
                0:       set_len(9'd0);
                1:       set_len(9'd300);
                default: set_len(9'($urandom_range(1, 40)));
            endcase
            set_div(16'($urandom_range(0, 4)));
            n = (len_m == 9'd0 || len_m > 9'd256) ? 256 : int'(len_m);
            p = int'(div_m) + 1;
            for (int i = 0; i < n; i++) ram_write(i, 8'($urandom));
            wb_read(A_LEN, 32'(len_m), 32'hFFFF_FFFF, "rand_len_readback");
            lp = 1'($urandom_range(0, 1));
            if (lp) play(1'b1, 1'b1, int'($urandom_range(0, n * p + p)));
            else    play(1'b0, 1'b0, 0);
        end

        repeat (4) @(negedge clk);
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
